// File: rtl/mips_pkg.sv
// Shared load-path types: load selector, load FSM states, byte-lane masks.
// Helpers are pure functions; they add no latency and apply no backpressure.
package mips_pkg;

    typedef enum logic [2:0] {
        LD_LW   = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LWL  = 3'd5,
        LD_LWR  = 3'd6,
        LD_RSVD = 3'd7
    } load_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } ldu_state_t;

    localparam logic [3:0] LANE_NONE = 4'b0000;
    localparam logic [3:0] LANE_B0   = 4'b0001;
    localparam logic [3:0] LANE_H0   = 4'b0011;
    localparam logic [3:0] LANE_H1   = 4'b1100;
    localparam logic [3:0] LANE_ALL  = 4'b1111;

    function automatic logic [3:0] lane_mask(input load_sel_t sel, input logic [1:0] k);
        logic [3:0] m;
        m = LANE_ALL;
        case (sel)
            LD_LB, LD_LBU: m = LANE_B0 << k;
            LD_LH, LD_LHU: m = k[1] ? LANE_H1 : LANE_H0;
            LD_LWL:        m = LANE_ALL >> (2'd3 - k);
            LD_LWR:        m = LANE_ALL << k;
            default:       m = LANE_ALL;
        endcase
        return m;
    endfunction

    // lwl/lwr exist precisely to handle unaligned words, so they never fault.
    function automatic logic misaligned(input load_sel_t sel, input logic [1:0] k);
        logic bad;
        bad = 1'b0;
        case (sel)
            LD_LW, LD_RSVD: bad = (k != 2'd0);
            LD_LH, LD_LHU:  bad = k[0];
            default:        bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_data_unit_if.sv
// Avalon-MM read-side bus between the load unit (master) and memory (slave).
// Pure wiring: no latency; the slave stalls the master with avm_waitrequest.
interface load_data_unit_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address, avm_read, avm_byteenable,
        input  avm_waitrequest, avm_readdata
    );

    modport slave (
        input  avm_address, avm_read, avm_byteenable,
        output avm_waitrequest, avm_readdata
    );
endinterface

// File: rtl/load_align.sv
// Formats a fetched word for writeback: lane select, sign/zero extend, lwl/lwr merge.
// Purely combinational, zero latency, no backpressure.
module load_align
    import mips_pkg::*;
(
    input  load_sel_t   sel,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] rt_old,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign shifted = word >> {offset, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (sel)
            LD_LB:  data = {{24{byte_v[7]}}, byte_v};
            LD_LBU: data = {24'd0, byte_v};
            LD_LH:  data = {{16{half_v[15]}}, half_v};
            LD_LHU: data = {16'd0, half_v};
            LD_LWL: begin
                case (offset)
                    2'd0:    data = {word[7:0],  rt_old[23:0]};
                    2'd1:    data = {word[15:0], rt_old[15:0]};
                    2'd2:    data = {word[23:0], rt_old[7:0]};
                    default: data = word;
                endcase
            end
            LD_LWR: begin
                case (offset)
                    2'd0:    data = word;
                    2'd1:    data = {rt_old[31:24], word[31:8]};
                    2'd2:    data = {rt_old[31:16], word[31:16]};
                    default: data = {rt_old[31:8],  word[31:24]};
                endcase
            end
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_data_unit.sv
// Load FSM: one word read per accepted start, result formatted and registered.
// load_done 2 cycles after start plus one per waitrequest cycle; starts while busy are dropped.
module load_data_unit
    import mips_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_start,
    input  logic [2:0]              load_sel,
    input  logic [31:0]             addr,
    input  logic [31:0]             rt_old,
    output logic                    busy,
    output logic                    load_done,
    output logic [31:0]             load_data,
    output logic                    addr_error,
    output logic                    timeout,
    load_data_unit_if.master        avm
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    ldu_state_t    state_q, state_d;
    load_sel_t     sel_q, sel_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   rt_q, rt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          aerr_q, aerr_d;
    logic          tout_q, tout_d;
    logic [31:0]   aligned;

    load_align u_align (
        .sel    (sel_q),
        .offset (addr_q[1:0]),
        .word   (avm.avm_readdata),
        .rt_old (rt_q),
        .data   (aligned)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        rt_d    = rt_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        aerr_d  = aerr_q;
        tout_d  = tout_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    sel_d  = load_sel_t'(load_sel);
                    addr_d = addr;
                    rt_d   = rt_old;
                    cnt_d  = '0;
                    data_d = '0;
                    aerr_d = 1'b0;
                    tout_d = 1'b0;
                    if (misaligned(load_sel_t'(load_sel), addr[1:0])) begin
                        aerr_d  = 1'b1;
                        state_d = ERR;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (!avm.avm_waitrequest) begin
                    data_d  = aligned;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    // Abort leaves load_data at the zero written on accept.
                    if (MAX_WAIT > 0 && cnt_d == MAX_CNT) begin
                        tout_d  = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= LD_LW;
            addr_q  <= '0;
            rt_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            aerr_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            rt_q    <= rt_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            aerr_q  <= aerr_d;
            tout_q  <= tout_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign load_done  = (state_q == DONE) || (state_q == ERR);
    assign load_data  = data_q;
    assign addr_error = aerr_q;
    assign timeout    = tout_q;

    // Bus outputs decode straight from the state flop so reset drops them immediately.
    assign avm.avm_read       = (state_q == REQ);
    assign avm.avm_address    = avm.avm_read ? {addr_q[31:2], 2'b00} : 32'd0;
    assign avm.avm_byteenable = avm.avm_read ? lane_mask(sel_q, addr_q[1:0]) : LANE_NONE;

endmodule

// File: tb/tb_load_data_unit.sv
// Randomized bench for load_data_unit with a small arithmetic reference model
// and a memory responder that inserts a chosen number of waitrequest cycles.
module tb_load_data_unit;

    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_start;
    logic [2:0]  load_sel;
    logic [31:0] addr;
    logic [31:0] rt_old;
    logic        busy;
    logic        load_done;
    logic [31:0] load_data;
    logic        addr_error;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_data_unit_if avm_if ();

    load_data_unit #(.MAX_WAIT(MAXW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_start (load_start),
        .load_sel   (load_sel),
        .addr       (addr),
        .rt_old     (rt_old),
        .busy       (busy),
        .load_done  (load_done),
        .load_data  (load_data),
        .addr_error (addr_error),
        .timeout    (timeout),
        .avm        (avm_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit model_mis(input logic [2:0] sel, input logic [31:0] a);
        if ((sel == 3'd0 || sel == 3'd7) && a[1:0] != 2'd0) return 1'b1;
        if ((sel == 3'd3 || sel == 3'd4) && a[0]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] sel, input logic [31:0] a);
        int k;
        int v;
        k = int'(a[1:0]);
        case (sel)
            3'd1, 3'd2: v = 1 << k;
            3'd3, 3'd4: v = 3 << k;
            3'd5:       v = (1 << (k + 1)) - 1;
            3'd6:       v = (15 << k) & 15;
            default:    v = 15;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_data(input logic [2:0] sel, input logic [31:0] a,
                                               input logic [31:0] rt, input logic [31:0] m);
        int          sh;
        logic [31:0] s;
        sh = 8 * int'(a[1:0]);
        s  = m >> sh;
        case (sel)
            3'd1:    return {{24{s[7]}}, s[7:0]};
            3'd2:    return {24'd0, s[7:0]};
            3'd3:    return {{16{s[15]}}, s[15:0]};
            3'd4:    return {16'd0, s[15:0]};
            3'd5:    return (m << (24 - sh)) | (rt & ((32'd1 << (24 - sh)) - 32'd1));
            3'd6:    return (m >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
            default: return m;
        endcase
    endfunction

    // inject: 0 none, 1 extra start in the first busy cycle, 2 extra start in the done cycle
    task automatic run_load(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] rt,
                            input logic [31:0] m, input int waits, input int inject);
        bit          mis;
        bit          to;
        bit          done;
        int          reads;
        int          cyc;
        int          exp_cyc;
        int          exp_reads;
        logic [31:0] exp_d;

        mis       = model_mis(sel, a);
        to        = !mis && (MAXW > 0) && (waits >= MAXW);
        exp_cyc   = mis ? 1 : (to ? MAXW + 1 : waits + 2);
        exp_reads = mis ? 0 : (to ? MAXW : waits + 1);
        exp_d     = (mis || to) ? 32'd0 : model_data(sel, a, rt, m);

        @(negedge clk);
        load_start = 1'b1;
        load_sel   = sel;
        addr       = a;
        rt_old     = rt;
        avm_if.avm_waitrequest = (waits > 0);
        avm_if.avm_readdata    = (waits > 0) ? $urandom : m;
        @(negedge clk);
        load_start = 1'b0;
        load_sel   = 3'($urandom);
        addr       = $urandom;
        rt_old     = $urandom;

        if (!mis) begin
            check("clr_data", load_data, 32'd0);
            check("clr_aerr", 32'(addr_error), 32'd0);
            check("clr_tout", 32'(timeout), 32'd0);
        end

        cyc   = 1;
        reads = 0;
        done  = 1'b0;
        while (!done && cyc <= 60) begin
            check("busy", 32'(busy), 32'd1);
            if (avm_if.avm_read) begin
                reads++;
                check("address", avm_if.avm_address, {a[31:2], 2'b00});
                check("byteen", {28'd0, avm_if.avm_byteenable}, model_be(sel, a));
            end
            avm_if.avm_waitrequest = avm_if.avm_read && (reads <= waits);
            avm_if.avm_readdata    = avm_if.avm_waitrequest ? $urandom : m;
            load_start = (inject == 1 && cyc == 1) || (inject == 2 && load_done);
            if (load_start) begin
                load_sel = 3'd0;
                addr     = 32'h0000_0500;
            end
            if (load_done) begin
                done = 1'b1;
                check("latency", 32'(cyc), 32'(exp_cyc));
                check("reads", 32'(reads), 32'(exp_reads));
                check("data", load_data, exp_d);
                check("addr_error", 32'(addr_error), 32'(mis));
                check("timeout", 32'(timeout), 32'(to));
            end
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);

        load_start             = 1'b0;
        avm_if.avm_waitrequest = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_read", 32'(avm_if.avm_read), 32'd0);
        check("done_pulse", 32'(load_done), 32'd0);
        check("hold_data", load_data, exp_d);
        check("hold_aerr", 32'(addr_error), 32'(mis));
        check("hold_tout", 32'(timeout), 32'(to));
    endtask

    initial begin
        reset_n    = 1'b0;
        load_start = 1'b0;
        load_sel   = 3'd0;
        addr       = 32'd0;
        rt_old     = 32'd0;
        avm_if.avm_waitrequest = 1'b0;
        avm_if.avm_readdata    = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_read", 32'(avm_if.avm_read), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_data", load_data, 32'd0);
        check("rst_be", {28'd0, avm_if.avm_byteenable}, 32'd0);
        reset_n = 1'b1;

        run_load(3'd0, 32'h0000_0100, $urandom, 32'h8899_AABB, 0, 0);
        check("lw_lit", load_data, 32'h8899_AABB);
        run_load(3'd1, 32'h0000_0103, 32'd0, 32'h8011_2233, 3, 0);
        check("lb_lit", load_data, 32'hFFFF_FF80);
        run_load(3'd2, 32'h0000_0103, 32'd0, 32'h8011_2233, 3, 0);
        check("lbu_lit", load_data, 32'h0000_0080);
        run_load(3'd3, 32'h0000_0102, 32'd0, 32'h9ABC_0001, 0, 0);
        check("lh_lit", load_data, 32'hFFFF_9ABC);
        run_load(3'd3, 32'h0000_0101, 32'd0, 32'h9ABC_0001, 0, 0);
        run_load(3'd5, 32'h0000_0201, 32'h1122_3344, 32'hAABB_CCDD, 0, 0);
        check("lwl_lit", load_data, 32'hCCDD_3344);
        run_load(3'd6, 32'h0000_0201, 32'h1122_3344, 32'hAABB_CCDD, 0, 0);
        check("lwr_lit", load_data, 32'h11AA_BBCC);
        run_load(3'd0, 32'h0000_0400, 32'd0, 32'h1234_5678, MAXW, 0);
        run_load(3'd0, 32'h0000_0404, 32'd0, 32'h1234_5678, MAXW - 1, 0);
        run_load(3'd7, 32'h0000_0408, 32'd0, 32'hCAFE_F00D, 1, 1);
        run_load(3'd4, 32'h0000_0402, 32'd0, 32'hF00D_0000, 0, 2);

        // Reset in the middle of a stalled read.
        @(negedge clk);
        load_start = 1'b1;
        load_sel   = 3'd0;
        addr       = 32'h0000_0300;
        avm_if.avm_waitrequest = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        @(negedge clk);
        check("mid_read", 32'(avm_if.avm_read), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_read", 32'(avm_if.avm_read), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_addr", avm_if.avm_address, 32'd0);
        check("arst_data", load_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        avm_if.avm_waitrequest = 1'b0;

        for (int i = 0; i < 150; i++) begin
            int w;
            w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
            run_load(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, w,
                     int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
